// File: rtl/rv_alu_pkg.sv
// Shared types for the execute-stage ALU: operation control encoding,
// alu_op constants, FSM state encoding and the instruction-field decoder.
package rv_alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // The base register ops fit in the low four bits. Bit 4 marks an
    // M-extension op, whose low three bits are then the instruction funct3.
    typedef enum logic [4:0] {
        ADD    = 5'd0,
        SUB    = 5'd1,
        SLL    = 5'd2,
        SLT    = 5'd3,
        SLTU   = 5'd4,
        XOR    = 5'd5,
        SRL    = 5'd6,
        SRA    = 5'd7,
        OR     = 5'd8,
        AND    = 5'd9,
        MUL    = 5'd16,
        MULH   = 5'd17,
        MULHSU = 5'd18,
        MULHU  = 5'd19,
        DIV    = 5'd20,
        DIVU   = 5'd21,
        REM    = 5'd22,
        REMU   = 5'd23
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

    // m_sel must already be masked to 0 when the mul/div unit is not built.
    function automatic alu_ctrl_e alu_decode(
        input logic [1:0] alu_op,
        input logic [2:0] funct3,
        input logic       funct7_5,
        input logic       m_sel,
        input logic       op_5
    );
        alu_ctrl_e ctrl;
        ctrl = ADD;
        case (alu_op)
            ALUOP_SUB: ctrl = SUB;
            ALUOP_FUNCT: begin
                if (op_5 && m_sel) begin
                    ctrl = alu_ctrl_e'({2'b10, funct3});
                end else begin
                    case (funct3)
                        3'b000:  ctrl = (op_5 && funct7_5) ? SUB : ADD;
                        3'b001:  ctrl = SLL;
                        3'b010:  ctrl = SLT;
                        3'b011:  ctrl = SLTU;
                        3'b100:  ctrl = XOR;
                        3'b101:  ctrl = funct7_5 ? SRA : SRL;
                        3'b110:  ctrl = OR;
                        default: ctrl = AND;
                    endcase
                end
            end
            default: ctrl = ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative M-extension unit: shift-add multiplier and restoring divider,
// one bit per cycle on magnitudes with a sign fix-up at the end. Both
// datapaths step every cycle; op selects which result is reported. done
// pulses during the last step and result is valid in that same cycle.
module alu_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic              run_q, run_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d, a_neg_q, a_neg_d, dz_q, dz_d, ovf_q, ovf_d;
    logic [XLEN-1:0]   a_q, a_d, abs_a_q, abs_a_d, abs_b_q, abs_b_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     add_sum, rem_shift;
    logic [2*XLEN-1:0] prod_step, prod_s;
    logic [XLEN-1:0]   rem_step, quo_step, rem_s, quo_s;

    // Operand signedness: mulh/mulhsu/div/rem treat A as signed, mulh/div/rem treat B as signed.
    always_comb begin
        a_neg = a[XLEN-1] && (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
        b_neg = b[XLEN-1] && (op == 3'b001 || op == 3'b100 || op == 3'b110);
        abs_a = a_neg ? -a : a;
        abs_b = b_neg ? -b : b;
    end

    // One multiply step and one restoring-divide step from the current state.
    always_comb begin
        add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, abs_a_q} : '0);
        prod_step = {add_sum, prod_q[XLEN-1:1]};
        rem_shift = {rem_q, quo_q[XLEN-1]};
        if (rem_shift >= {1'b0, abs_b_q}) begin
            rem_step = XLEN'(rem_shift - {1'b0, abs_b_q});
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    // Sign fix-up and special cases, applied to the values the final step produces.
    always_comb begin
        prod_s = neg_q ? -prod_step : prod_step;
        quo_s  = neg_q ? -quo_step : quo_step;
        rem_s  = a_neg_q ? -rem_step : rem_step;
        case (op_q)
            3'b000:                 result = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = dz_q ? '1 : (ovf_q ? a_q : quo_s);
            default:                result = dz_q ? a_q : (ovf_q ? '0 : rem_s);
        endcase
    end

    assign done = run_q && (count_q == LAST);

    // Load operands on start, otherwise advance one bit per cycle while running.
    always_comb begin
        run_d   = run_q;
        count_d = count_q;
        op_d    = op_q;
        neg_d   = neg_q;
        a_neg_d = a_neg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        abs_a_d = abs_a_q;
        abs_b_d = abs_b_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        if (start) begin
            run_d   = 1'b1;
            count_d = '0;
            op_d    = op;
            neg_d   = a_neg ^ b_neg;
            a_neg_d = a_neg;
            dz_d    = (b == '0);
            ovf_d   = (op == 3'b100 || op == 3'b110) && (a == MOST_NEG) && (b == '1);
            a_d     = a;
            abs_a_d = abs_a;
            abs_b_d = abs_b;
            prod_d  = {{XLEN{1'b0}}, abs_b};
            rem_d   = '0;
            quo_d   = abs_a;
        end else if (run_q) begin
            prod_d  = prod_step;
            rem_d   = rem_step;
            quo_d   = quo_step;
            count_d = count_q + 1'b1;
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q   <= 1'b0;
            count_q <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            abs_a_q <= '0;
            abs_b_q <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            run_q   <= run_d;
            count_q <= count_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            a_neg_q <= a_neg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            abs_a_q <= abs_a_d;
            abs_b_q <= abs_b_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with integrated decode and valid/ready handshakes.
// Define ALU_MULDIV_EN to build the iterative M-extension unit; without it
// funct7_0 is ignored and every op completes one cycle after acceptance.
module alu_exec_unit
    import rv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic            op_5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SHAMT_W = $clog2(XLEN);
`ifdef ALU_MULDIV_EN
    localparam logic MD_EN = 1'b1;
`else
    localparam logic MD_EN = 1'b0;
`endif

    alu_state_e      state_q, state_d;
    logic            out_valid_q, out_valid_d, zero_q, zero_d;
    logic [XLEN-1:0] result_q, result_d;

    alu_ctrl_e            ctrl;
    logic                 is_m, accept, md_done;
    logic [SHAMT_W-1:0]   shamt;
    logic [XLEN-1:0]      base_result, md_result;

    assign ctrl   = alu_decode(alu_op, funct3, funct7_5, funct7_0 & MD_EN, op_5);
    assign is_m   = ctrl[4];
    assign shamt  = src_b[SHAMT_W-1:0];
    assign in_ready = !reset && ((state_q == S_IDLE) || (state_q == S_DONE && out_ready));
    assign accept = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
    logic md_start;
    assign md_start = accept && is_m;
    assign busy     = (state_q == S_BUSY);

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op     (ctrl[2:0]),
        .a      (src_a),
        .b      (src_b),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign md_done   = 1'b0;
    assign md_result = '0;
    assign busy      = 1'b0;
`endif

    // Single-cycle base operations.
    always_comb begin
        base_result = '0;
        case (ctrl)
            ADD:     base_result = src_a + src_b;
            SUB:     base_result = src_a - src_b;
            SLL:     base_result = src_a << shamt;
            SLT:     base_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            SLTU:    base_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            XOR:     base_result = src_a ^ src_b;
            SRL:     base_result = src_a >> shamt;
            SRA:     base_result = $signed(src_a) >>> shamt;
            OR:      base_result = src_a | src_b;
            AND:     base_result = src_a & src_b;
            default: base_result = '0;
        endcase
    end

    // Handshake FSM: retire the held result, then take any newly accepted op.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        case (state_q)
            S_BUSY: begin
                if (md_done) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    result_d    = md_result;
                    zero_d      = (md_result == '0);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (accept) begin
            if (is_m) begin
                state_d     = S_BUSY;
                out_valid_d = 1'b0;
            end else begin
                state_d     = S_DONE;
                out_valid_d = 1'b1;
                result_d    = base_result;
                zero_d      = (base_result == '0);
            end
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (XLEN=32): directed corner cases
// followed by randomized operations against an arithmetic reference model.
// Follows ALU_MULDIV_EN the same way the design does.
module tb_alu_exec_unit;

    localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_op = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_5 = 1'b0;
    logic        funct7_0 = 1'b0;
    logic        op_5 = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .funct7_0  (funct7_0),
        .op_5      (op_5),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_is_m(input logic [1:0] aop, input logic f70, input logic op5);
        return MD && (aop == 2'b10) && op5 && f70;
    endfunction

    // Reference: RISC-V semantics computed with plain integer arithmetic.
    function automatic logic [31:0] ref_alu(input logic [1:0] aop, input logic [2:0] f3,
                                            input logic f75, input logic f70, input logic op5,
                                            input logic [31:0] a, input logic [31:0] b);
        int          sa, sb, sh;
        longint      pb;
        logic [63:0] p;
        bit          ovf;
        sa  = a;
        sb  = b;
        sh  = int'(b[4:0]);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (aop == 2'b01) return a - b;
        if (aop != 2'b10) return a + b;
        if (ref_is_m(aop, f70, op5)) begin
            case (f3)
                3'd0: begin p = 64'(longint'(sa) * longint'(sb)); return p[31:0]; end
                3'd1: begin p = 64'(longint'(sa) * longint'(sb)); return p[63:32]; end
                3'd2: begin pb = longint'({32'b0, b}); p = 64'(longint'(sa) * pb); return p[63:32]; end
                3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
                3'd4: begin
                    if (b == 0) return 32'hFFFF_FFFF;
                    if (ovf) return a;
                    return 32'(sa / sb);
                end
                3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: begin
                    if (b == 0) return a;
                    if (ovf) return 32'd0;
                    return 32'(sa % sb);
                end
                default: return (b == 0) ? a : a % b;
            endcase
        end
        case (f3)
            3'd0:    return (op5 && f75) ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return f75 ? 32'(sa >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Issue one op (back-to-back with any held result), wait for it, then
    // optionally hold out_ready low for 'stall' cycles.
    task automatic run_op(input logic [1:0] aop, input logic [2:0] f3, input logic f75,
                          input logic f70, input logic op5, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic [31:0] exp;
        int          exp_lat, lat, busy_cnt;
        bit          ready_bad;
        exp     = ref_alu(aop, f3, f75, f70, op5, a, b);
        exp_lat = ref_is_m(aop, f70, op5) ? XLEN + 1 : 1;
        alu_op = aop; funct3 = f3; funct7_5 = f75; funct7_0 = f70; op_5 = op5;
        src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check_eq("in_ready_at_issue", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = (stall == 0);
        lat = 1; busy_cnt = 0; ready_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_cnt++;
            if (in_ready) ready_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
        check_eq("in_ready_low_busy", 64'(ready_bad), 64'd0);
        check_eq("result", 64'(result), 64'(exp));
        check_eq("zero", 64'(zero), 64'(exp == 0));
        $display("[TB] op=%0d f3=%0d f75=%0d f70=%0d op5=%0d a=%h b=%h result=%h exp=%h lat=%0d stall=%0d",
                 aop, f3, f75, f70, op5, a, b, result, exp, lat, stall);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_eq("hold_result", 64'(result), 64'(exp));
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1;
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_result", 64'(result), 64'd0);
        check_eq("reset_zero", 64'(zero), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1 check_eq("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed cases
        run_op(2'b10, 3'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 0);
        run_op(2'b10, 3'd5, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0024, 0);
        run_op(2'b10, 3'd5, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0024, 0);
        run_op(2'b10, 3'd1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 0);
        run_op(2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 0);
        run_op(2'b10, 3'd6, 1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 0);
        run_op(2'b10, 3'd4, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b10, 3'd6, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b10, 3'd0, 1'b0, 1'b1, 1'b1, 32'd3, 32'd4, 0);
        run_op(2'b10, 3'd7, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 5);
        run_op(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 2);
        run_op(2'b11, 3'd0, 1'b0, 1'b0, 1'b0, 32'd10, 32'd20, 0);

        // Reset partway through a divu aborts it; the next op runs normally
        alu_op = 2'b10; funct3 = 3'd5; funct7_5 = 1'b0; funct7_0 = 1'b1; op_5 = 1'b1;
        src_a = 32'd1000; src_b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("abort_out_valid", 64'(out_valid), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_result", 64'(result), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_no_result", 64'(out_valid), 64'd0);
        run_op(2'b10, 3'd5, 1'b0, 1'b1, 1'b1, 32'd1000, 32'd7, 0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests_run);
        $fatal(1, "time limit");
    end

endmodule
